// File: rtl/bcd_updown_cnt.sv
// rtl/bcd_updown_cnt.sv - N-digit BCD up/down counter with load, wrap/saturate and status flags
module bcd_updown_cnt #(
  parameter int DIGITS   = 2,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  CLK,
  input  logic                  CLRN,
  input  logic                  CLR_CNT,
  input  logic                  LD,
  input  logic [4*DIGITS-1:0]   LD_VAL,
  input  logic                  INC,
  input  logic                  DEC,
  output logic [4*DIGITS-1:0]   CNT,
  output logic                  CARRY,
  output logic                  BORROW,
  output logic                  OVF,
  output logic                  BADLD,
  output logic                  ZERO,
  output logic                  MAX
);

  localparam int W = 4*DIGITS;

  logic [W-1:0]    inc_val;
  logic [W-1:0]    dec_val;
  logic [DIGITS:0] cy_chain;
  logic [DIGITS:0] bw_chain;
  logic            ld_ok;

  // Ripple carry/borrow per digit; a digit only moves when every lower digit rolls over.
  always_comb begin
    inc_val     = '0;
    dec_val     = '0;
    cy_chain    = '0;
    bw_chain    = '0;
    ld_ok       = 1'b1;
    cy_chain[0] = 1'b1;
    bw_chain[0] = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (!cy_chain[k])
        inc_val[4*k +: 4] = CNT[4*k +: 4];
      else if (CNT[4*k +: 4] == 4'd9)
        inc_val[4*k +: 4] = 4'd0;
      else
        inc_val[4*k +: 4] = CNT[4*k +: 4] + 4'd1;
      cy_chain[k+1] = cy_chain[k] && (CNT[4*k +: 4] == 4'd9);

      if (!bw_chain[k])
        dec_val[4*k +: 4] = CNT[4*k +: 4];
      else if (CNT[4*k +: 4] == 4'd0)
        dec_val[4*k +: 4] = 4'd9;
      else
        dec_val[4*k +: 4] = CNT[4*k +: 4] - 4'd1;
      bw_chain[k+1] = bw_chain[k] && (CNT[4*k +: 4] == 4'd0);

      if (LD_VAL[4*k +: 4] > 4'd9)
        ld_ok = 1'b0;
    end
  end

  assign ZERO = (CNT == '0);
  assign MAX  = (CNT == {DIGITS{4'h9}});

  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      CNT    <= '0;
      CARRY  <= 1'b0;
      BORROW <= 1'b0;
      OVF    <= 1'b0;
      BADLD  <= 1'b0;
    end else begin
      CARRY  <= 1'b0;
      BORROW <= 1'b0;
      BADLD  <= 1'b0;
      if (CLR_CNT) begin
        CNT <= '0;
        OVF <= 1'b0;
      end else if (LD) begin
        if (ld_ok)
          CNT <= LD_VAL;
        else
          BADLD <= 1'b1;
      end else if (INC && !DEC) begin
        if (MAX) begin
          OVF <= 1'b1;
          if (!SATURATE) begin
            CNT   <= '0;
            CARRY <= 1'b1;
          end
        end else begin
          CNT <= inc_val;
        end
      end else if (DEC && !INC) begin
        if (ZERO) begin
          OVF <= 1'b1;
          if (!SATURATE) begin
            CNT    <= {DIGITS{4'h9}};
            BORROW <= 1'b1;
          end
        end else begin
          CNT <= dec_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_updown_cnt.sv
// tb/tb_bcd_updown_cnt.sv - directed checks of bcd_updown_cnt in wrap, 3-digit and saturate builds
module tb_bcd_updown_cnt;

  logic clk;
  logic clrn;
  int   n_tests;
  int   n_fail;

  // 2-digit wrapping instance
  logic       a_clr, a_ld, a_inc, a_dec;
  logic [7:0] a_val, a_cnt;
  logic       a_carry, a_borrow, a_ovf, a_badld, a_zero, a_max;
  // 3-digit wrapping instance
  logic        b_clr, b_ld, b_inc, b_dec;
  logic [11:0] b_val, b_cnt;
  logic        b_carry, b_borrow, b_ovf, b_badld, b_zero, b_max;
  // 2-digit saturating instance
  logic       s_clr, s_ld, s_inc, s_dec;
  logic [7:0] s_val, s_cnt;
  logic       s_carry, s_borrow, s_ovf, s_badld, s_zero, s_max;

  bcd_updown_cnt #(.DIGITS(2), .SATURATE(1'b0)) u_a (
    .CLK(clk), .CLRN(clrn), .CLR_CNT(a_clr), .LD(a_ld), .LD_VAL(a_val),
    .INC(a_inc), .DEC(a_dec), .CNT(a_cnt), .CARRY(a_carry), .BORROW(a_borrow),
    .OVF(a_ovf), .BADLD(a_badld), .ZERO(a_zero), .MAX(a_max)
  );

  bcd_updown_cnt #(.DIGITS(3), .SATURATE(1'b0)) u_b (
    .CLK(clk), .CLRN(clrn), .CLR_CNT(b_clr), .LD(b_ld), .LD_VAL(b_val),
    .INC(b_inc), .DEC(b_dec), .CNT(b_cnt), .CARRY(b_carry), .BORROW(b_borrow),
    .OVF(b_ovf), .BADLD(b_badld), .ZERO(b_zero), .MAX(b_max)
  );

  bcd_updown_cnt #(.DIGITS(2), .SATURATE(1'b1)) u_s (
    .CLK(clk), .CLRN(clrn), .CLR_CNT(s_clr), .LD(s_ld), .LD_VAL(s_val),
    .INC(s_inc), .DEC(s_dec), .CNT(s_cnt), .CARRY(s_carry), .BORROW(s_borrow),
    .OVF(s_ovf), .BADLD(s_badld), .ZERO(s_zero), .MAX(s_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_step(input logic clr, input logic ld, input logic inc, input logic dec,
                        input logic [7:0] val);
    a_clr = clr; a_ld = ld; a_inc = inc; a_dec = dec; a_val = val;
    tick();
    a_clr = 0; a_ld = 0; a_inc = 0; a_dec = 0;
  endtask

  task automatic b_step(input logic clr, input logic ld, input logic inc, input logic dec,
                        input logic [11:0] val);
    b_clr = clr; b_ld = ld; b_inc = inc; b_dec = dec; b_val = val;
    tick();
    b_clr = 0; b_ld = 0; b_inc = 0; b_dec = 0;
  endtask

  task automatic s_step(input logic clr, input logic ld, input logic inc, input logic dec,
                        input logic [7:0] val);
    s_clr = clr; s_ld = ld; s_inc = inc; s_dec = dec; s_val = val;
    tick();
    s_clr = 0; s_ld = 0; s_inc = 0; s_dec = 0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clrn = 1'b1;
    a_clr = 0; a_ld = 0; a_inc = 0; a_dec = 0; a_val = '0;
    b_clr = 0; b_ld = 0; b_inc = 0; b_dec = 0; b_val = '0;
    s_clr = 0; s_ld = 0; s_inc = 0; s_dec = 0; s_val = '0;
    #2 clrn = 1'b0;
    #1;
    check("reset_cnt", a_cnt, 8'h00);
    check("reset_flags", {a_carry, a_borrow, a_ovf, a_badld}, 4'b0000);
    check("reset_zero_max", {a_zero, a_max}, 2'b10);
    tick();
    clrn = 1'b1;

    // Set OVF, then show async reset clears count and OVF mid-count.
    a_step(0, 1, 0, 0, 8'h99);
    check("max_flag", {a_zero, a_max}, 2'b01);
    a_step(0, 0, 1, 0, 8'h00);
    check("wrap_pre_ovf", a_ovf, 1'b1);
    a_step(0, 1, 0, 0, 8'h46);
    a_step(0, 0, 1, 0, 8'h00);
    check("mid_cnt_47", a_cnt, 8'h47);
    check("ld_keeps_ovf", a_ovf, 1'b1);
    #2 clrn = 1'b0;
    #1;
    check("async_rst_cnt", a_cnt, 8'h00);
    check("async_rst_ovf", a_ovf, 1'b0);
    tick();
    clrn = 1'b1;

    a_step(0, 1, 0, 0, 8'h59);
    check("ld_59", a_cnt, 8'h59);
    check("nonlimit_zero_max", {a_zero, a_max}, 2'b00);

    // Wrap up
    a_step(0, 1, 0, 0, 8'h98);
    a_step(0, 0, 1, 0, 8'h00);
    check("wrap_99", a_cnt, 8'h99);
    check("wrap_99_carry", a_carry, 1'b0);
    a_step(0, 0, 1, 0, 8'h00);
    check("wrap_00", a_cnt, 8'h00);
    check("wrap_carry", a_carry, 1'b1);
    check("wrap_ovf", a_ovf, 1'b1);
    check("wrap_zero", a_zero, 1'b1);
    a_step(0, 0, 1, 0, 8'h00);
    check("wrap_01", a_cnt, 8'h01);
    check("wrap_carry_off", a_carry, 1'b0);

    // 2-digit decrement across a digit boundary
    a_step(0, 1, 0, 0, 8'h10);
    a_step(0, 0, 0, 1, 8'h00);
    check("dec_09", a_cnt, 8'h09);
    check("dec_09_borrow", a_borrow, 1'b0);

    // Invalid load and priority
    a_step(0, 1, 0, 0, 8'h37);
    a_step(0, 1, 0, 0, 8'h3A);
    check("badld_hold", a_cnt, 8'h37);
    check("badld_pulse", a_badld, 1'b1);
    a_step(0, 1, 0, 0, 8'hA3);
    check("badld_hi_digit", a_cnt, 8'h37);
    check("badld_again", a_badld, 1'b1);
    a_step(0, 0, 0, 0, 8'h00);
    check("badld_off", a_badld, 1'b0);
    a_step(0, 1, 1, 0, 8'h12);
    check("ld_over_inc", a_cnt, 8'h12);
    check("ld_over_inc_ovf", a_ovf, 1'b1);
    a_step(1, 1, 0, 0, 8'h34);
    check("clr_over_ld", a_cnt, 8'h00);
    check("clr_ovf", a_ovf, 1'b0);

    // INC and DEC together hold
    a_step(0, 1, 0, 0, 8'h50);
    for (int i = 0; i < 4; i++) begin
      a_step(0, 0, 1, 1, 8'h00);
      check("incdec_hold", a_cnt, 8'h50);
      check("incdec_pulses", {a_carry, a_borrow, a_badld}, 3'b000);
    end

    // 3-digit cascade
    b_step(0, 1, 0, 0, 12'h100);
    b_step(0, 0, 0, 1, 12'h000);
    check("b_099", b_cnt, 12'h099);
    b_step(0, 0, 0, 1, 12'h000);
    check("b_098", b_cnt, 12'h098);
    b_step(0, 1, 0, 0, 12'h199);
    b_step(0, 0, 1, 0, 12'h000);
    check("b_inc_200", b_cnt, 12'h200);
    b_step(0, 1, 0, 0, 12'h000);
    b_step(0, 0, 0, 1, 12'h000);
    check("b_wrap_999", b_cnt, 12'h999);
    check("b_borrow", b_borrow, 1'b1);
    check("b_ovf", b_ovf, 1'b1);
    check("b_max", b_max, 1'b1);
    b_step(0, 0, 0, 1, 12'h000);
    check("b_998", b_cnt, 12'h998);
    check("b_borrow_off", b_borrow, 1'b0);

    // Saturate
    s_step(0, 1, 0, 0, 8'h99);
    check("s_ovf_init", s_ovf, 1'b0);
    for (int i = 0; i < 3; i++) begin
      s_step(0, 0, 1, 0, 8'h00);
      check("s_hold_99", s_cnt, 8'h99);
      check("s_no_carry", s_carry, 1'b0);
      check("s_ovf", s_ovf, 1'b1);
    end
    s_step(1, 0, 0, 0, 8'h00);
    check("s_clr_cnt", s_cnt, 8'h00);
    check("s_clr_ovf", s_ovf, 1'b0);
    s_step(0, 0, 0, 1, 8'h00);
    check("s_hold_00", s_cnt, 8'h00);
    check("s_dec_ovf", s_ovf, 1'b1);
    check("s_no_borrow", s_borrow, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_updown_cnt.md
# bcd_updown_cnt

Parametrised N-digit BCD up/down counter, the successor to the 2-digit increment-only BCD counter. It adds a digit-count parameter, decrement, parallel load with BCD validation, and a selectable wrap or saturate mode. It also provides a registered carry/borrow pulse and a sticky overflow flag. It feeds display and timekeeping logic, and cascades into further counters through CARRY/BORROW.

## Interface
- DIGITS, default 2: number of BCD digits; legal range 1–8; count width is 4*DIGITS.
- SATURATE, default 0: 0 = wrap at the limits; 1 = hold at the limits.
- CLK  input  1  system clock; all state updates on the rising edge.
- CLRN  input  1  asynchronous active-low reset; clears all state immediately.
- CLR_CNT  input  1  synchronous clear of the count and sticky flags.
- LD  input  1  synchronous parallel load of LD_VAL.
- LD_VAL  input  4*DIGITS  load value; digit k is in bits [4k+3:4k]; digit 0 is the least significant.
- INC  input  1  count up by one.
- DEC  input  1  count down by one.
- CNT  output  4*DIGITS  registered BCD count.
- CARRY  output  1  registered one-cycle pulse: an up-count wrapped from all-9s to zero.
- BORROW  output  1  registered one-cycle pulse: a down-count wrapped from zero to all-9s.
- OVF  output  1  sticky flag: a limit was crossed or hit while counting in SATURATE mode.
- BADLD  output  1  registered one-cycle pulse: a load was rejected for an invalid digit.
- ZERO  output  1  combinational; asserted when CNT is all zeros.
- MAX  output  1  combinational; asserted when every digit of CNT is 9.

## Operation
- Reset (CLRN=0, asynchronous): CNT=0, CARRY=0, BORROW=0, OVF=0, BADLD=0. This takes effect regardless of CLK and of any operation in progress.
- Per-edge priority: CLR_CNT, then LD, then count.
  - **CLR_CNT=1:** CNT←0 and OVF←0; all pulse outputs are 0.
  - **LD=1:** if every digit of LD_VAL is ≤9, CNT←LD_VAL. Otherwise CNT holds and BADLD pulses. OVF is unchanged in both cases.
  - **INC=1, DEC=0:** add one. Each digit that was 9 with a carry-in becomes 0 and carries to the next digit; otherwise the digit increments and the carry stops.
  - **DEC=1, INC=0:** subtract one. Each digit that was 0 with a borrow-in becomes 9 and borrows from the next digit; otherwise the digit decrements and the borrow stops.
  - **INC=DEC=1, or INC=DEC=0:** hold; no pulses.
- Limit behaviour, SATURATE=0:
  - INC at MAX: CNT←0, CARRY pulses, OVF←1.
  - DEC at ZERO: CNT←all-9s, BORROW pulses, OVF←1.
- Limit behaviour, SATURATE=1:
  - INC at MAX: CNT holds, OVF←1, CARRY stays 0.
  - DEC at ZERO: CNT holds, OVF←1, BORROW stays 0.
- OVF stays set until CLR_CNT or CLRN.
- CNT never holds a digit >9. This follows from the load validation and the count arithmetic, with no extra state.
- CARRY, BORROW and BADLD are mutually exclusive in any cycle.

## Timing
- Latency is one cycle: the inputs sampled at edge n are reflected in CNT and the pulse outputs after edge n.
- CARRY, BORROW and BADLD are high for exactly the cycle after the causing edge. They are low otherwise, including when the same event repeats on consecutive edges with no deassertion in between: each qualifying edge produces its own one-cycle pulse.
- ZERO and MAX are decoded combinationally from the registered CNT. They therefore change in the same cycle as CNT.
- The carry and borrow chain through all DIGITS settles within one clock. There is no multicycle path.
- Releasing CLRN mid-operation: the first rising edge with CLRN=1 applies the normal priority rules starting from CNT=0.

## Test plan
- **Reset and load (DIGITS=2):**
  - Assert CLRN=0 mid-count at CNT=0x47 → CNT=0x00 and all flags 0 immediately, without waiting for a CLK edge.
  - LD with LD_VAL=0x59 → CNT=0x59.
- **Wrap up (DIGITS=2, SATURATE=0):** load 0x98, then INC for 3 edges → CNT=0x99, then 0x00 with CARRY=1 for one cycle and OVF=1, then 0x01 with CARRY=0.
- **Wrap down with cascade (DIGITS=3):** load 0x100, then DEC for 2 edges → 0x099, then 0x098. Then load 0x000 and DEC → CNT=0x999, BORROW pulses, OVF=1.
- **Saturate (DIGITS=2, SATURATE=1):**
  - At 0x99, INC for 3 edges → CNT stays 0x99, OVF=1, CARRY never asserts.
  - Then CLR_CNT → CNT=0x00 and OVF=0.
  - Then DEC → CNT stays 0x00 and OVF=1.
- **Invalid load and priority (DIGITS=2):**
  - At CNT=0x37, LD with LD_VAL=0x3A → CNT=0x37 and BADLD pulses one cycle.
  - LD=1 with INC=1 and LD_VAL=0x12 → CNT=0x12.
  - CLR_CNT=1 with LD=1 → CNT=0x00.
- **Simultaneous INC and DEC, and the flags (DIGITS=2):** at 0x50, INC=DEC=1 for 4 edges → CNT stays 0x50 with no pulses. ZERO=1 only at 0x00, and MAX=1 only at 0x99.
